// File: rtl/conv_mac_engine.sv
// Multi-channel convolution MAC: accumulates TAPS beats of CH parallel products,
// then adds bias, rescales, optionally applies ReLU and saturates to DW bits.
module conv_mac_engine #(
  parameter int unsigned DW   = 16,
  parameter int unsigned FRAC = 8,
  parameter int unsigned CH   = 3,
  parameter int unsigned TAPS = 9,
  parameter int unsigned AW   = 2*DW + $clog2(CH*TAPS) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CH*DW-1:0] x_bus,
  input  logic [CH*DW-1:0] w_bus,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    bias,
  input  logic             relu_en,
  output logic [DW-1:0]    out_data,
  output logic             out_sat,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned CW = (TAPS > 1) ? $clog2(TAPS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [CW-1:0]        tap_cnt;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] beat_sum;
  logic signed [AW-1:0] acc_base;
  logic signed [AW-1:0] bias_ext;
  logic signed [AW-1:0] acc_final;
  logic signed [AW-1:0] shifted;
  logic signed [AW-1:0] relu_val;
  logic [DW-1:0]        res_data;
  logic                 res_sat;
  logic                 accept;
  logic                 last_beat;
  logic                 done;

  // Dot product of one beat: full-width signed products, sign-extended and summed.
  function automatic logic signed [AW-1:0] dot(input logic [CH*DW-1:0] xv,
                                               input logic [CH*DW-1:0] wv);
    logic signed [DW-1:0]   a;
    logic signed [DW-1:0]   b;
    logic signed [2*DW-1:0] p;
    logic signed [AW-1:0]   s;
    s = '0;
    for (int i = 0; i < int'(CH); i++) begin
      a = xv[i*DW +: DW];
      b = wv[i*DW +: DW];
      p = (2*DW)'(a) * (2*DW)'(b);
      s = s + AW'(p);
    end
    return s;
  endfunction

  assign accept    = in_valid & in_ready;
  assign last_beat = (tap_cnt == CW'(TAPS - 1));
  assign done      = accept & last_beat;

  // Result path; the first beat of a frame ignores the stale accumulator.
  always_comb begin
    beat_sum  = dot(x_bus, w_bus);
    acc_base  = (tap_cnt == '0) ? '0 : acc;
    bias_ext  = AW'($signed(bias)) <<< FRAC;
    acc_final = acc_base + beat_sum + bias_ext;
    shifted   = acc_final >>> FRAC;
    relu_val  = (relu_en && shifted[AW-1]) ? '0 : shifted;
    res_data  = relu_val[DW-1:0];
    res_sat   = 1'b0;
    if (relu_val > SAT_MAX) begin
      res_data = {1'b0, {(DW-1){1'b1}}};
      res_sat  = 1'b1;
    end else if (relu_val < SAT_MIN) begin
      res_data = {1'b1, {(DW-1){1'b0}}};
      res_sat  = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = last_beat ? OUT : ACC;
      ACC:     if (done) state_nxt = OUT;
      OUT:     if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_cnt   <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_nxt != OUT);
      out_valid <= (state_nxt == OUT);
      if (accept) begin
        acc     <= acc_base + beat_sum;
        tap_cnt <= last_beat ? '0 : tap_cnt + CW'(1);
      end
      if (done) begin
        out_data <= res_data;
        out_sat  <= res_sat;
      end
    end
  end

endmodule
